vinsn_dispatcher: RTL and testbench
===================================

VINSN_DISPATCHER -- requirements
Module: vinsn_dispatcher

Interface
REQ-001 SHALL have parameter HazardCheck, default 1, meaning 1 enables the RAW/WAW register-hazard stall and 0 stalls on insn_id reuse only.
REQ-002 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port issue_valid_i, input, 1 bit: the upstream instruction is valid.
REQ-005 SHALL have port issue_ready_o, output, 1 bit: the dispatcher accepts issue_req_i this cycle.
REQ-006 SHALL have port issue_req_i, input, issue_req_t: the instruction from the issue stage.
REQ-007 SHALL have port op_req_valid_o, output, 1 bit: operand-request valid.
REQ-008 SHALL have port op_req_ready_i, input, 1 bit: the operand requester accepts the request.
REQ-009 SHALL have port op_req_o, output, op_req_t: the operand-fetch descriptor.
REQ-010 SHALL have port vfu_req_valid_o, output, NrVFU bits: one-hot request valid, indexed by vfu_e.
REQ-011 SHALL have port vfu_req_ready_i, input, NrVFU bits: per-VFU ready.
REQ-012 SHALL have port vfu_req_o, output, vfu_req_t: the request shared by all VFUs.
REQ-013 SHALL have port insn_done_i, input, InsnIDNum bits: one-hot-per-ID completion pulses from the VFUs.
REQ-014 SHALL have port nop_done_valid_o, output, 1 bit: pulse marking a zero-length instruction retired internally.
REQ-015 SHALL have port nop_done_id_o, output, insn_id_t: the ID of that retired instruction.
REQ-016 SHALL have port busy_o, output, 1 bit: FSM is in DISPATCH or any table entry is valid.

Function
REQ-017 SHALL implement a 2-state FSM with states IDLE and DISPATCH.
REQ-018 SHALL assert issue_ready_o only in IDLE, when the ID table entry for issue_req_i.insn_id is invalid and no hazard exists (REQ-022).
REQ-019 SHALL classify an issue_req_i as a nop when vstart >= vl: accept it, pulse nop_done_valid_o and nop_done_id_o in the next cycle, stay IDLE, and leave the table unwritten.
REQ-020 SHALL, on a non-nop accept, register the request and go to DISPATCH with these pending flags:
- op_pend = |GetOpQueue(vop, use_vs)
- vfu_pend = 1
REQ-021 SHALL set a table entry in the same edge as the accept:
- valid = 1
- writes_vd = (vop != VSE)
- vd = vs[VD]
REQ-022 SHALL define hazard, when HazardCheck is 1, as any valid writing entry E where either condition holds:
- RAW: use_vs[i] is set and vs[i] == E.vd, for any i in 0..2
- WAW: the new instruction writes vd and vs[VD] == E.vd
REQ-023 SHALL drive op_req_valid_o = op_pend and vfu_req_valid_o = vfu_pend << GetVFUByVOp(vop) in DISPATCH; both SHALL be 0 in IDLE.
REQ-024 SHALL hold op_req_o and vfu_req_o stable while pending; once a flag clears, the contents of the corresponding output are don't-care.
REQ-025 SHALL build op_req_o as follows:
- vs, vew, vl and vstart are copied from the request
- queue_req = GetOpQueue(vop, use_vs)
- insn_id is included only when DUMP_VRF_ACCESS is defined
REQ-026 SHALL build vfu_req_o as follows:
- vew_vd = vew[VD]
- vd = vs[VD]
- vop, vl, vstart, use_vs, scalar_op and insn_id are copied from the request
REQ-027 SHALL clear op_pend on op_req_valid_o && op_req_ready_i, and clear vfu_pend on the selected valid && ready; the two handshakes are independent and may complete in either order or in the same cycle.
REQ-028 SHALL return to IDLE on the edge where the last pending flag clears; the next accept is possible in the following cycle.
REQ-029 SHALL give a minimum latency of 1 cycle from accept to valid, and a minimum throughput of 1 instruction per 2 cycles.
REQ-030 SHALL clear table entry k on insn_done_i[k]; if done and a set target the same entry in one cycle, set wins (this is unreachable for the same ID because of REQ-018).
REQ-031 SHALL apply done clears in the cycle they arrive; hazard and ID checks use the pre-clear table state, so a stalled instruction proceeds one cycle after the done.
REQ-032 SHALL ignore insn_done_i for entries that are already invalid.
REQ-033 SHALL never drop or duplicate a handshake while back-pressured by any ready held low for any duration.

Reset
REQ-034 SHALL, while rst_i is sampled high, put the FSM in IDLE, clear every table entry, clear both pending flags and clear nop_done_valid_o.
REQ-035 SHALL abandon any in-flight instruction when rst_i asserts during DISPATCH, with all valid outputs at 0 in the cycle after the reset edge.
REQ-036 SHALL hold issue_ready_o, op_req_valid_o, vfu_req_valid_o, nop_done_valid_o and busy_o at 0 during reset.

Verification
REQ-037 SHALL cover: VADD id=1, vs1=2, vs2=3, vd=4, use_vs=3'b011, vl=16, with both readies high -> op_req and vfu_req[VALU] valid 1 cycle after accept with queue_req=3'b011, FSM IDLE after 1 cycle, issue_ready_o high again.
REQ-038 SHALL cover: VLE id=2 -> op_req_valid_o never asserts, vfu_req_valid_o=3'b010; then VADD id=3 with vs1=vd(VLE) -> issue_ready_o low until insn_done_i[2], accepted the following cycle.
REQ-039 SHALL cover: VSE id=4, use_vs=3'b100; op_req_ready_i held low 5 cycles while VSU ready -> vfu handshake completes first, op_req_valid_o stays high with stable op_req_o until ready, queue_req=3'b100.
REQ-040 SHALL cover: issue with insn_id equal to an in-flight ID -> stall until its done; VADD with vl=8, vstart=8 -> nop_done_valid_o pulse with that ID, no downstream valid.
REQ-041 SHALL cover: rst_i asserted mid-DISPATCH with 2 valid table entries -> all valids 0 and busy_o 0 after the reset edge, and a prior hazard no longer stalls.
REQ-042 SHALL cover: HazardCheck=0 with a RAW-dependent pair -> second instruction accepted without waiting for done.

Source files
------------

// File: rtl/vinsn_dispatcher.sv
// Vector instruction dispatcher: scoreboards in-flight IDs and registers,
// then hands each instruction to the operand requester and its VFU.
package vinsn_pkg;
  localparam int NrVFU = 3;
  localparam int InsnIDNum = 8;
  localparam int VS1 = 0;
  localparam int VS2 = 1;
  localparam int VD = 2;

  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
  typedef logic [4:0] vreg_t;
  typedef logic [1:0] vew_t;
  typedef logic [7:0] vlen_t;

  typedef enum logic [2:0] {
    VADD, VSUB, VAND, VOR, VLE, VSE
  } vop_e;

  typedef enum logic [1:0] {
    VALU, VLDU, VSU
  } vfu_e;

  typedef struct packed {
    insn_id_t          insn_id;
    vop_e              vop;
    logic [2:0][4:0]   vs;
    logic [2:0]        use_vs;
    logic [2:0][1:0]   vew;
    vlen_t             vl;
    vlen_t             vstart;
    logic [31:0]       scalar_op;
  } issue_req_t;

  typedef struct packed {
    logic [2:0][4:0]   vs;
    logic [2:0][1:0]   vew;
    vlen_t             vl;
    vlen_t             vstart;
    logic [2:0]        queue_req;
`ifdef DUMP_VRF_ACCESS
    insn_id_t          insn_id;
`endif
  } op_req_t;

  typedef struct packed {
    vop_e              vop;
    vew_t              vew_vd;
    vreg_t             vd;
    vlen_t             vl;
    vlen_t             vstart;
    logic [2:0]        use_vs;
    logic [31:0]       scalar_op;
    insn_id_t          insn_id;
  } vfu_req_t;

  // Loads take no VRF operands; everything else reads what it uses.
  function automatic logic [2:0] get_op_queue(
    input vop_e vop, input logic [2:0] use_vs);
    return (vop == VLE) ? 3'b000 : use_vs;
  endfunction

  function automatic vfu_e get_vfu_by_vop(input vop_e vop);
    vfu_e f;
    unique case (vop)
      VLE:     f = VLDU;
      VSE:     f = VSU;
      default: f = VALU;
    endcase
    return f;
  endfunction
endpackage

module vinsn_dispatcher
  import vinsn_pkg::*;
#(
  parameter int HazardCheck = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  issue_req_t           issue_req_i,
  output logic                 op_req_valid_o,
  input  logic                 op_req_ready_i,
  output op_req_t              op_req_o,
  output logic [NrVFU-1:0]     vfu_req_valid_o,
  input  logic [NrVFU-1:0]     vfu_req_ready_i,
  output vfu_req_t             vfu_req_o,
  input  logic [InsnIDNum-1:0] insn_done_i,
  output logic                 nop_done_valid_o,
  output insn_id_t             nop_done_id_o,
  output logic                 busy_o
);

  typedef enum logic {IDLE, DISPATCH} state_e;

  state_e                         state;
  issue_req_t                     req_q;
  logic                           op_pend;
  logic                           vfu_pend;
  logic [InsnIDNum-1:0]           tbl_valid;
  logic [InsnIDNum-1:0]           tbl_wr;
  logic [InsnIDNum-1:0][4:0]      tbl_vd;

  logic       hazard;
  logic       new_wr;
  logic       is_nop;
  logic       accept;
  logic       op_fire;
  logic       vfu_fire;
  logic       op_next;
  logic       vfu_next;
  logic [2:0] new_queue;
  vfu_e       vfu_sel;
  logic [NrVFU-1:0] vfu_onehot;

  assign new_wr    = (issue_req_i.vop != VSE);
  assign is_nop    = (issue_req_i.vstart >= issue_req_i.vl);
  assign new_queue = get_op_queue(issue_req_i.vop,
                                  issue_req_i.use_vs);

  always_comb begin
    hazard = 1'b0;
    if (HazardCheck != 0) begin
      for (int k = 0; k < InsnIDNum; k++) begin
        if (tbl_valid[k] && tbl_wr[k]) begin
          for (int i = 0; i < 3; i++) begin
            if (issue_req_i.use_vs[i] &&
                issue_req_i.vs[i] == tbl_vd[k])
              hazard = 1'b1;
          end
          if (new_wr && issue_req_i.vs[VD] == tbl_vd[k])
            hazard = 1'b1;
        end
      end
    end
  end

  assign issue_ready_o = !rst_i && (state == IDLE) &&
                         !tbl_valid[issue_req_i.insn_id] &&
                         !hazard;
  assign accept = issue_valid_i && issue_ready_o;

  assign vfu_sel = get_vfu_by_vop(req_q.vop);

  always_comb begin
    vfu_onehot = '0;
    vfu_onehot[vfu_sel] = 1'b1;
  end

  assign op_req_valid_o  = !rst_i && (state == DISPATCH) && op_pend;
  assign vfu_req_valid_o = (!rst_i && (state == DISPATCH) && vfu_pend)
                           ? vfu_onehot : '0;

  assign op_fire  = op_req_valid_o && op_req_ready_i;
  assign vfu_fire = |(vfu_req_valid_o & vfu_req_ready_i);
  assign op_next  = op_pend && !op_fire;
  assign vfu_next = vfu_pend && !vfu_fire;

  always_comb begin
    op_req_o           = '0;
    op_req_o.vs        = req_q.vs;
    op_req_o.vew       = req_q.vew;
    op_req_o.vl        = req_q.vl;
    op_req_o.vstart    = req_q.vstart;
    op_req_o.queue_req = get_op_queue(req_q.vop, req_q.use_vs);
`ifdef DUMP_VRF_ACCESS
    op_req_o.insn_id   = req_q.insn_id;
`endif
  end

  always_comb begin
    vfu_req_o           = '0;
    vfu_req_o.vop       = req_q.vop;
    vfu_req_o.vew_vd    = req_q.vew[VD];
    vfu_req_o.vd        = req_q.vs[VD];
    vfu_req_o.vl        = req_q.vl;
    vfu_req_o.vstart    = req_q.vstart;
    vfu_req_o.use_vs    = req_q.use_vs;
    vfu_req_o.scalar_op = req_q.scalar_op;
    vfu_req_o.insn_id   = req_q.insn_id;
  end

  assign busy_o = !rst_i && ((state == DISPATCH) || (|tbl_valid));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      op_pend          <= 1'b0;
      vfu_pend         <= 1'b0;
      tbl_valid        <= '0;
      nop_done_valid_o <= 1'b0;
    end else begin
      nop_done_valid_o <= accept && is_nop;
      if (accept)
        nop_done_id_o <= issue_req_i.insn_id;
      // A set in the same edge overrides the done clear.
      tbl_valid <= tbl_valid & ~insn_done_i;
      if (accept && !is_nop) begin
        tbl_valid[issue_req_i.insn_id] <= 1'b1;
        tbl_wr[issue_req_i.insn_id]    <= new_wr;
        tbl_vd[issue_req_i.insn_id]    <= issue_req_i.vs[VD];
      end
      unique case (state)
        IDLE: begin
          if (accept && !is_nop) begin
            req_q    <= issue_req_i;
            op_pend  <= |new_queue;
            vfu_pend <= 1'b1;
            state    <= DISPATCH;
          end
        end
        DISPATCH: begin
          op_pend  <= op_next;
          vfu_pend <= vfu_next;
          if (!op_next && !vfu_next)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vinsn_dispatcher.sv
// Directed bench for vinsn_dispatcher: vector table plus
// hand-written hazard, back-pressure and reset sequences.
module tb_vinsn_dispatcher;
  import vinsn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_valid;
  logic                 issue_valid_nh;
  issue_req_t           issue_req;
  logic                 op_ready;
  logic [NrVFU-1:0]     vfu_ready;
  logic [InsnIDNum-1:0] insn_done;

  logic             issue_ready, op_valid, nop_valid, busy;
  op_req_t          op_req;
  logic [NrVFU-1:0] vfu_valid;
  vfu_req_t         vfu_req;
  insn_id_t         nop_id;

  logic             issue_ready_nh, op_valid_nh, nop_valid_nh, busy_nh;
  op_req_t          op_req_nh;
  logic [NrVFU-1:0] vfu_valid_nh;
  vfu_req_t         vfu_req_nh;
  insn_id_t         nop_id_nh;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vinsn_dispatcher #(.HazardCheck(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_req_i(issue_req),
    .op_req_valid_o(op_valid), .op_req_ready_i(op_ready),
    .op_req_o(op_req),
    .vfu_req_valid_o(vfu_valid), .vfu_req_ready_i(vfu_ready),
    .vfu_req_o(vfu_req),
    .insn_done_i(insn_done),
    .nop_done_valid_o(nop_valid), .nop_done_id_o(nop_id),
    .busy_o(busy)
  );

  vinsn_dispatcher #(.HazardCheck(0)) dut_nh (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid_nh), .issue_ready_o(issue_ready_nh),
    .issue_req_i(issue_req),
    .op_req_valid_o(op_valid_nh), .op_req_ready_i(op_ready),
    .op_req_o(op_req_nh),
    .vfu_req_valid_o(vfu_valid_nh), .vfu_req_ready_i(vfu_ready),
    .vfu_req_o(vfu_req_nh),
    .insn_done_i(insn_done),
    .nop_done_valid_o(nop_valid_nh), .nop_done_id_o(nop_id_nh),
    .busy_o(busy_nh)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic issue_req_t mk(input int id, input vop_e op,
      input int s1, input int s2, input int d,
      input logic [2:0] u, input int vl, input int vst);
    issue_req_t r;
    r.insn_id   = insn_id_t'(id);
    r.vop       = op;
    r.vs[VS1]   = 5'(s1);
    r.vs[VS2]   = 5'(s2);
    r.vs[VD]    = 5'(d);
    r.use_vs    = u;
    r.vew       = {2'd2, 2'd1, 2'd0};
    r.vl        = 8'(vl);
    r.vstart    = 8'(vst);
    r.scalar_op = 32'hA5A5_0000 + 32'(id);
    return r;
  endfunction

  task automatic done(input int id);
    @(negedge clk);
    insn_done = '0;
    insn_done[id] = 1'b1;
    @(negedge clk);
    insn_done = '0;
  endtask

  typedef struct {
    int         id;
    vop_e       op;
    int         s1, s2, d;
    logic [2:0] u;
    int         vl, vst;
    logic       e_op;
    logic [2:0] e_vfu;
    logic [2:0] e_q;
    logic       e_nop;
  } vec_t;

  vec_t vecs[7];
  issue_req_t probe;

  initial begin
    vecs[0] = '{1, VADD, 2, 3, 4, 3'b011, 16, 0,
                1'b1, 3'b001, 3'b011, 1'b0};
    vecs[1] = '{5, VSUB, 7, 8, 9, 3'b001, 4, 0,
                1'b1, 3'b001, 3'b001, 1'b0};
    vecs[2] = '{2, VLE, 0, 0, 4, 3'b000, 8, 0,
                1'b0, 3'b010, 3'b000, 1'b0};
    vecs[3] = '{4, VSE, 0, 0, 6, 3'b100, 8, 2,
                1'b1, 3'b100, 3'b100, 1'b0};
    vecs[4] = '{3, VADD, 2, 3, 4, 3'b011, 8, 8,
                1'b0, 3'b000, 3'b000, 1'b1};
    vecs[5] = '{6, VAND, 10, 11, 12, 3'b011, 1, 0,
                1'b1, 3'b001, 3'b011, 1'b0};
    vecs[6] = '{7, VOR, 1, 2, 3, 3'b011, 5, 9,
                1'b0, 3'b000, 3'b000, 1'b1};
    probe = mk(0, VSE, 0, 0, 31, 3'b000, 0, 0);

    rst = 1'b1;
    issue_valid = 1'b1;
    issue_valid_nh = 1'b0;
    issue_req = probe;
    op_ready = 1'b1;
    vfu_ready = '1;
    insn_done = '0;

    @(negedge clk);
    #1;
    chk("rst_ready", issue_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op", op_valid, 0);
    chk("rst_vfu", vfu_valid, 0);
    @(negedge clk);
    chk("rst_nop", nop_valid, 0);
    rst = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);

    foreach (vecs[n]) begin
      vec_t v;
      v = vecs[n];
      @(negedge clk);
      issue_req = mk(v.id, v.op, v.s1, v.s2, v.d, v.u, v.vl, v.vst);
      issue_valid = 1'b1;
      #1;
      chk("vec_ready", issue_ready, 1);
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      chk("vec_op_valid", op_valid, 32'(v.e_op));
      chk("vec_vfu_valid", vfu_valid, 32'(v.e_vfu));
      chk("vec_nop_valid", nop_valid, 32'(v.e_nop));
      if (v.e_nop)
        chk("vec_nop_id", nop_id, v.id);
      if (v.e_op) begin
        chk("vec_queue", op_req.queue_req, 32'(v.e_q));
        chk("vec_op_vl", op_req.vl, v.vl);
      end
      if (!v.e_nop) begin
        chk("vec_vfu_vd", vfu_req.vd, v.d);
        chk("vec_vfu_id", vfu_req.insn_id, v.id);
        chk("vec_vfu_op", vfu_req.vop, 32'(v.op));
        chk("vec_vfu_vew", vfu_req.vew_vd, 2);
      end
      @(negedge clk);
      issue_req = probe;
      #1;
      chk("vec_op_clr", op_valid, 0);
      chk("vec_vfu_clr", vfu_valid, 0);
      chk("vec_nop_clr", nop_valid, 0);
      chk("vec_idle_ready", issue_ready, 1);
      chk("vec_busy", busy, 32'(!v.e_nop));
      done(v.id);
      #1;
      chk("vec_busy_end", busy, 0);
    end

    // RAW on a load destination stalls until the load's done.
    @(negedge clk);
    issue_req = mk(2, VLE, 0, 0, 10, 3'b000, 8, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("raw_vle_op", op_valid, 0);
    chk("raw_vle_vfu", vfu_valid, 3'b010);
    @(negedge clk);
    issue_req = mk(3, VADD, 10, 11, 12, 3'b011, 8, 0);
    issue_valid = 1'b1;
    #1;
    chk("raw_stall0", issue_ready, 0);
    @(negedge clk);
    #1;
    chk("raw_stall1", issue_ready, 0);
    @(negedge clk);
    insn_done[2] = 1'b1;
    #1;
    chk("raw_stall_done", issue_ready, 0);
    @(negedge clk);
    insn_done = '0;
    #1;
    chk("raw_release", issue_ready, 1);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("raw_op", op_valid, 1);
    chk("raw_vfu", vfu_valid, 3'b001);
    done(3);

    // Store with operand back-pressure; VSU handshake completes first.
    @(negedge clk);
    op_ready = 1'b0;
    issue_req = mk(4, VSE, 0, 0, 6, 3'b100, 8, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    issue_req = probe;
    #1;
    chk("bp_op0", op_valid, 1);
    chk("bp_vfu0", vfu_valid, 3'b100);
    chk("bp_vd0", vfu_req.vd, 6);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("bp_op_hold", op_valid, 1);
      chk("bp_vfu_once", vfu_valid, 0);
      chk("bp_queue", op_req.queue_req, 3'b100);
      chk("bp_vs_vd", op_req.vs[VD], 6);
      chk("bp_ready_low", issue_ready, 0);
    end
    op_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_op_done", op_valid, 0);
    chk("bp_idle", issue_ready, 1);
    done(4);

    // Reuse of an in-flight ID stalls until that ID completes.
    @(negedge clk);
    issue_req = mk(1, VADD, 2, 3, 4, 3'b011, 16, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_req = mk(1, VSUB, 20, 21, 22, 3'b011, 4, 0);
    #1;
    chk("id_stall0", issue_ready, 0);
    @(negedge clk);
    #1;
    chk("id_stall1", issue_ready, 0);
    insn_done[1] = 1'b1;
    @(negedge clk);
    insn_done = '0;
    #1;
    chk("id_release", issue_ready, 1);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("id_vfu_vd", vfu_req.vd, 22);
    done(1);

    // Reset in DISPATCH with two live table entries.
    @(negedge clk);
    issue_req = mk(1, VADD, 2, 3, 4, 3'b011, 16, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    vfu_ready = '0;
    issue_req = mk(2, VLE, 0, 0, 5, 3'b000, 8, 0);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_vfu_held", vfu_valid, 3'b010);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vfu_ready = '1;
    issue_req = mk(3, VADD, 4, 5, 13, 3'b011, 8, 0);
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_vfu", vfu_valid, 0);
    chk("mrst_op", op_valid, 0);
    chk("mrst_no_hazard", issue_ready, 1);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    done(3);

    // Without hazard checking a RAW pair issues back to back.
    @(negedge clk);
    issue_req = mk(2, VLE, 0, 0, 10, 3'b000, 8, 0);
    issue_valid_nh = 1'b1;
    #1;
    chk("nh_ready0", issue_ready_nh, 1);
    @(negedge clk);
    issue_valid_nh = 1'b0;
    #1;
    chk("nh_vfu0", vfu_valid_nh, 3'b010);
    @(negedge clk);
    issue_req = mk(3, VADD, 10, 11, 12, 3'b011, 8, 0);
    issue_valid_nh = 1'b1;
    #1;
    chk("nh_raw_ready", issue_ready_nh, 1);
    @(negedge clk);
    issue_valid_nh = 1'b0;
    #1;
    chk("nh_op1", op_valid_nh, 1);
    chk("nh_vfu1", vfu_valid_nh, 3'b001);
    done(2);
    done(3);
    #1;
    chk("nh_busy_end", busy_nh, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
